// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU data bus: load/store unit state encoding
// and the bus widths of the 256-entry, 8-bit data memory.
package cpu_bus_pkg;

   localparam int BUS_ADDR_W = 8;
   localparam int BUS_DATA_W = 8;

   // Load/store unit FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from the execute stage,
// runs a single-beat cyc/stb/we/ack transaction on the data bus and returns
// a one-cycle response pulse. A watchdog ends unacknowledged transactions
// with an error response.
//
// Request handshake: a request transfers at a rising edge where both
// req_valid_i and req_ready_o are high; req_ready_o is high only in IDLE and
// the core holds the request stable until then. rsp_valid_o has no ready:
// it is a one-cycle pulse the core must take when it appears.
module load_store_unit
   import cpu_bus_pkg::*;
#(
   parameter int ADDR_W         = BUS_ADDR_W,
   parameter int DATA_W         = BUS_DATA_W,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              mem_cyc_o,
   output logic              mem_stb_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   // Next-state, watchdog and response logic; every register holds by default.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               state_d = BUS;
               cyc_d   = 1'b1;
               we_d    = req_we_i;
               addr_d  = req_addr_i;
               wdata_d = req_data_i;
               cnt_d   = '0;
            end
         end

         BUS: begin
            // Ack has priority over the watchdog at the same edge.
            if (mem_ack_i) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = we_q ? wdata_q : mem_data_i;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // One forced idle bus cycle so the slave's registered read ack
         // from this transaction cannot be taken by the next one.
         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_data_o  = rsp_data_q;
   assign mem_cyc_o   = cyc_q;
   assign mem_stb_o   = cyc_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_data_o  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a data-memory slave model with selectable ack
// behaviour, a table of directed transactions, hand-written back-to-back and
// mid-transaction reset sequences, and randomized transactions checked
// against a transaction-level reference model.
module tb_load_store_unit;

   localparam int TIMEOUT = 15;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       req_valid_i;
   logic       req_ready_o;
   logic       req_we_i;
   logic [7:0] req_addr_i;
   logic [7:0] req_data_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;
   logic       rsp_err_o;
   logic       mem_cyc_o;
   logic       mem_stb_o;
   logic       mem_we_o;
   logic [7:0] mem_addr_o;
   logic [7:0] mem_data_o;
   logic [7:0] mem_data_i;
   logic       mem_ack_i;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   load_store_unit #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_data_i  (req_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .mem_cyc_o   (mem_cyc_o),
      .mem_stb_o   (mem_stb_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_data_i  (mem_data_i),
      .mem_ack_i   (mem_ack_i)
   );

   // ---------------- slave model ----------------
   // mode 0: writes ack combinationally, reads ack one cycle late (registered)
   // mode 1: ack tied low
   // mode 2: ack combinationally once stb has been high for slv_dly cycles
   int         slv_mode = 0;
   int         slv_dly  = 0;
   logic       init_mem = 1'b1;
   logic [7:0] smem [256];
   logic       rd_ack_q = 1'b0;
   logic [7:0] rd_data_q = 8'h00;
   int         dly_cnt = 0;

   always @(posedge clk_i) begin
      rd_ack_q  <= mem_cyc_o && mem_stb_o && !mem_we_o && !rd_ack_q;
      rd_data_q <= smem[mem_addr_o];
      if (mem_cyc_o && mem_stb_o) dly_cnt <= dly_cnt + 1;
      else                        dly_cnt <= 0;
      if (init_mem) begin
         for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
      end else if (mem_cyc_o && mem_stb_o && mem_we_o && mem_ack_i) begin
         smem[mem_addr_o] <= mem_data_o;
      end
   end

   always_comb begin
      mem_ack_i  = 1'b0;
      mem_data_i = 8'h00;
      case (slv_mode)
         0: begin
            mem_ack_i  = (mem_cyc_o && mem_stb_o && mem_we_o) || rd_ack_q;
            mem_data_i = rd_data_q;
         end
         2: begin
            mem_ack_i  = mem_cyc_o && mem_stb_o && (dly_cnt == slv_dly);
            mem_data_i = smem[mem_addr_o];
         end
         default: begin
            mem_ack_i  = 1'b0;
            mem_data_i = 8'h00;
         end
      endcase
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [256];

   // Transaction-level outcome: the ack arrives in BUS cycle ack_at
   // (0 = first cycle) or never; the watchdog allows BUS cycles 0..TIMEOUT-1.
   function automatic void model(input logic we, input logic [7:0] addr,
                                 input logic [7:0] data, input int mode,
                                 input int dly, output logic [7:0] e_data,
                                 output logic e_err, output int e_lat);
      int ack_at;
      if (mode == 1)      ack_at = -1;
      else if (mode == 2) ack_at = dly;
      else                ack_at = we ? 0 : 1;
      if (ack_at < 0 || ack_at >= TIMEOUT) begin
         e_data = 8'h00;
         e_err  = 1'b1;
         e_lat  = TIMEOUT;
      end else begin
         e_err  = 1'b0;
         e_lat  = ack_at + 1;
         e_data = we ? data : ref_mem[addr];
         if (we) ref_mem[addr] = data;
      end
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge. Returns at a falling edge with the unit idle.
   // lat = number of rising edges after the handshake edge until rsp_valid_o.
   task automatic run_req(input string tag, input logic we, input logic [7:0] addr,
                          input logic [7:0] data, output logic [7:0] r_data,
                          output logic r_err, output int lat);
      int   guard;
      logic bus_ok;
      logic got;
      guard = 0;
      while (!req_ready_o && guard < 50) begin
         @(negedge clk_i);
         guard++;
      end
      chk({tag, " ready_before_req"}, {31'd0, req_ready_o}, 32'd1);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_data_i  = data;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i  = 8'h00;
      req_data_i  = 8'h00;
      got    = 1'b0;
      bus_ok = 1'b1;
      lat    = -1;
      r_data = 8'h00;
      r_err  = 1'b0;
      for (int i = 0; i <= 40 && !got; i++) begin
         if (rsp_valid_o) begin
            got    = 1'b1;
            lat    = i;
            r_data = rsp_data_o;
            r_err  = rsp_err_o;
            if (mem_cyc_o || mem_stb_o || req_ready_o) bus_ok = 1'b0;
         end else begin
            if (!(mem_cyc_o && mem_stb_o && mem_we_o == we && mem_addr_o == addr &&
                  mem_data_o == data && !req_ready_o)) bus_ok = 1'b0;
            @(negedge clk_i);
         end
      end
      chk({tag, " rsp_within_budget"}, {31'd0, got}, 32'd1);
      chk({tag, " bus_held_then_dropped"}, {31'd0, bus_ok}, 32'd1);
      if (got) begin
         @(negedge clk_i);
         chk({tag, " rsp_single_pulse"}, {31'd0, rsp_valid_o}, 32'd0);
         chk({tag, " ready_after_resp"}, {31'd0, req_ready_o}, 32'd1);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      int         mode;
      int         dly;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic [7:0] r_data, e_data;
      logic       r_err, e_err;
      int         lat, e_lat;
      logic [7:0] seen_q [$];
      int         rise_at [$];
      logic       prev_stb;
      logic       addr_ok, no_rsp;

      vecs[0]  = '{1'b1, 8'h10, 8'hA5, 0, 0,  8'hA5, 1'b0, 1};   // store
      vecs[1]  = '{1'b0, 8'h10, 8'h00, 0, 0,  8'hA5, 1'b0, 2};   // load back
      vecs[2]  = '{1'b1, 8'h11, 8'h3C, 0, 0,  8'h3C, 1'b0, 1};
      vecs[3]  = '{1'b1, 8'hFF, 8'h5A, 0, 0,  8'h5A, 1'b0, 1};   // top address
      vecs[4]  = '{1'b0, 8'hFF, 8'h00, 0, 0,  8'h5A, 1'b0, 2};
      vecs[5]  = '{1'b0, 8'h10, 8'h00, 1, 0,  8'h00, 1'b1, 15};  // ack tied low
      vecs[6]  = '{1'b1, 8'h20, 8'h77, 1, 0,  8'h00, 1'b1, 15};  // store times out
      vecs[7]  = '{1'b0, 8'h20, 8'h00, 0, 0,  8'h00, 1'b0, 2};   // not written
      vecs[8]  = '{1'b0, 8'h11, 8'h00, 2, 14, 8'h3C, 1'b0, 15};  // ack at last cycle
      vecs[9]  = '{1'b1, 8'h21, 8'hC3, 2, 14, 8'hC3, 1'b0, 15};
      vecs[10] = '{1'b0, 8'h21, 8'h00, 2, 15, 8'h00, 1'b1, 15};  // ack one too late
      vecs[11] = '{1'b0, 8'h21, 8'h00, 2, 0,  8'hC3, 1'b0, 1};
      vecs[12] = '{1'b0, 8'h11, 8'h00, 2, 3,  8'h3C, 1'b0, 4};

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

      // ---- reset ----
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      req_addr_i  = 8'h00;
      req_data_i  = 8'h00;
      repeat (3) @(negedge clk_i);
      init_mem = 1'b0;
      chk("reset req_ready", {31'd0, req_ready_o}, 32'd1);
      chk("reset rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("reset rsp_err",   {31'd0, rsp_err_o},   32'd0);
      chk("reset rsp_data",  {24'd0, rsp_data_o},  32'd0);
      chk("reset cyc_stb_we", {29'd0, mem_cyc_o, mem_stb_o, mem_we_o}, 32'd0);
      chk("reset mem_addr",  {24'd0, mem_addr_o},  32'd0);
      chk("reset mem_data",  {24'd0, mem_data_o},  32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // ---- directed table ----
      foreach (vecs[i]) begin
         slv_mode = vecs[i].mode;
         slv_dly  = vecs[i].dly;
         run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                 r_data, r_err, lat);
         chk($sformatf("vec%0d rsp_data", i), {24'd0, r_data}, {24'd0, vecs[i].exp_data});
         chk($sformatf("vec%0d rsp_err", i),  {31'd0, r_err},  {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d latency", i),  lat, vecs[i].exp_lat);
         if (vecs[i].we && !vecs[i].exp_err) ref_mem[vecs[i].addr] = vecs[i].data;
      end
      slv_mode = 0;

      // ---- back-to-back loads with req_valid held high ----
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 8'h10;
      req_data_i  = 8'h00;
      prev_stb    = mem_stb_o;
      addr_ok     = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_i);
         if (rsp_valid_o) seen_q.push_back(rsp_data_o);
         if (mem_stb_o && !prev_stb) begin
            rise_at.push_back(c);
            if (rise_at.size() == 1) req_addr_i = 8'h11;
            else begin
               req_valid_i = 1'b0;
               if (mem_addr_o != 8'h11) addr_ok = 1'b0;
            end
         end
         prev_stb = mem_stb_o;
      end
      req_valid_i = 1'b0;
      chk("b2b strobe_count", rise_at.size(), 2);
      if (rise_at.size() == 2) chk("b2b handshake_spacing", rise_at[1] - rise_at[0], 4);
      chk("b2b second_addr", {31'd0, addr_ok}, 32'd1);
      chk("b2b rsp_count", seen_q.size(), 2);
      if (seen_q.size() == 2) begin
         chk("b2b rsp0_data", {24'd0, seen_q[0]}, 32'hA5);
         chk("b2b rsp1_data", {24'd0, seen_q[1]}, 32'h3C);
      end
      repeat (2) @(negedge clk_i);

      // ---- reset during the BUS cycle of a load ----
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 8'h10;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      chk("midrst in_bus", {30'd0, mem_cyc_o, mem_stb_o}, 32'd3);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("midrst cyc_stb", {30'd0, mem_cyc_o, mem_stb_o}, 32'd0);
      chk("midrst ready", {31'd0, req_ready_o}, 32'd1);
      chk("midrst rsp_data", {24'd0, rsp_data_o}, 32'd0);
      no_rsp = !rsp_valid_o;
      repeat (3) begin
         @(negedge clk_i);
         if (rsp_valid_o) no_rsp = 1'b0;
      end
      chk("midrst no_rsp_pulse", {31'd0, no_rsp}, 32'd1);
      model(1'b1, 8'hFF, 8'h99, 0, 0, e_data, e_err, e_lat);
      run_req("midrst store_ff", 1'b1, 8'hFF, 8'h99, r_data, r_err, lat);
      chk("midrst store_ff data", {24'd0, r_data}, {24'd0, e_data});
      chk("midrst store_ff lat", lat, e_lat);
      model(1'b0, 8'hFF, 8'h00, 0, 0, e_data, e_err, e_lat);
      run_req("midrst load_ff", 1'b0, 8'hFF, 8'h00, r_data, r_err, lat);
      chk("midrst load_ff data", {24'd0, r_data}, {24'd0, e_data});
      chk("midrst load_ff err", {31'd0, r_err}, {31'd0, e_err});

      // ---- randomized transactions against the reference model ----
      for (int t = 0; t < 40; t++) begin
         logic       we;
         logic [7:0] addr, data;
         int         r, mode, dly;
         we   = 1'($urandom_range(0, 1));
         addr = (t % 3 == 0) ? 8'h10 + 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         data = 8'($urandom_range(0, 255));
         r    = $urandom_range(0, 9);
         mode = (r < 6) ? 0 : (r < 8) ? 2 : 1;
         dly  = $urandom_range(0, 16);
         slv_mode = mode;
         slv_dly  = dly;
         model(we, addr, data, mode, dly, e_data, e_err, e_lat);
         run_req($sformatf("rnd%0d", t), we, addr, data, r_data, r_err, lat);
         chk($sformatf("rnd%0d rsp_data", t), {24'd0, r_data}, {24'd0, e_data});
         chk($sformatf("rnd%0d rsp_err", t),  {31'd0, r_err},  {31'd0, e_err});
         chk($sformatf("rnd%0d latency", t),  lat, e_lat);
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end
      slv_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Bus master between the CPU execute stage and the 8-bit data memory slave.
- Accepts one load/store request at a time from the core on a valid/ready handshake.
- Runs a single-beat cyc/stb/we/ack transaction on the data bus and returns a one-cycle response pulse with read data or an error flag.
- A watchdog counter ends any transaction that gets no ack within a bounded number of cycles.

Parameters:
- ADDR_W, 8, address width; matches the 256-entry data memory.
- DATA_W, 8, data width.
- TIMEOUT_CYCLES, 15, maximum number of cycles in BUS without ack before the transaction ends with an error; legal range 2..255.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  core presents a request.
- req_ready_o  out  1  unit can accept a request; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  request address.
- req_data_i  in  DATA_W  store data.
- rsp_valid_o  out  1  single-cycle response pulse.
- rsp_data_o  out  DATA_W  load data, or store data echo on a store; 0 on error.
- rsp_err_o  out  1  qualified by rsp_valid_o; 1 = timeout.
- mem_cyc_o  out  1  bus cycle active.
- mem_stb_o  out  1  strobe.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_W  bus address.
- mem_data_o  out  DATA_W  bus write data.
- mem_data_i  in  DATA_W  bus read data; sampled only when mem_ack_i=1.
- mem_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (rst_i high at a rising edge):
  - state=IDLE.
  - req_ready_o=1 (comb from IDLE).
  - rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0.
  - mem_cyc_o=0, mem_stb_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
  - Timeout counter=0.
- Reset mid-transaction: bus signals drop at that edge and no response is issued. The slave is left with at most one stale registered read ack, which clears because stb is low.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o at an edge: latch we/addr/data into the mem_* output registers, set mem_cyc_o=mem_stb_o=1, clear the counter, go to BUS.
- BUS:
  - cyc, stb, we, addr and data are held stable; req_ready_o=0.
  - Counter increments every cycle without ack.
  - If mem_ack_i=1 at an edge:
    - capture rsp_data_o = mem_data_i for a load, or the latched store data for a store;
    - rsp_err_o=0, rsp_valid_o=1;
    - drop cyc/stb;
    - go to RESP.
  - Otherwise, if counter == TIMEOUT_CYCLES-1:
    - rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0;
    - drop cyc/stb;
    - go to RESP.
  - Ack wins over timeout when both occur at the same edge.
- RESP:
  - rsp_valid_o high for exactly this one cycle; cyc/stb low.
  - Next edge: rsp_valid_o=0, go to IDLE.
  - The forced idle bus cycle is required: the memory's registered read ack would otherwise be seen as a stale ack for a back-to-back transaction.
  - rsp_data_o and rsp_err_o hold their values until the next response.
- Latency, with handshake at edge N:
  - Store: slave acks combinationally, so rsp_valid_o is high in the cycle after edge N+1.
  - Load: slave acks one cycle late, so rsp_valid_o is high in the cycle after edge N+2.
  - Next request is accepted at the earliest one cycle after the rsp_valid_o cycle.
  - Peak throughput: one store per 3 cycles, one load per 4 cycles.
- Address/data pass through unmodified; there is no wrap logic.
- Address 8'hFF is legal.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- req_valid_i outside IDLE is ignored; the core must hold the request until ready.

Decomposition:
- Shared package cpu_bus_pkg:
  - lsu_state_t enum {IDLE, BUS, RESP};
  - localparams BUS_ADDR_W=8, BUS_DATA_W=8;
  - also used by DataMemory-side testbenches.
- No sub-module; the counter and FSM stay inline (roughly 150 lines).

Test Plan:
- Store addr 8'h10 data 8'hA5 -> one BUS cycle with we=1; rsp_valid 2 cycles after handshake; rsp_data=8'hA5, err=0; memory[8'h10]=8'hA5.
- Load 8'h10 after the store -> stb held 2 cycles; rsp_valid 3 cycles after handshake; rsp_data=8'hA5, err=0.
- Back-to-back load 8'h10 then load 8'h11 (memory 8'h3C) with req_valid held high -> stb low for at least 1 cycle between them; second rsp_data=8'h3C, never a stale 8'hA5.
- Ack tied 0 -> after 15 BUS cycles: rsp_valid=1, err=1, data=8'h00; cyc/stb low; req_ready returns 1 two cycles later.
- rst_i asserted during the BUS cycle of a load -> cyc/stb=0 the next cycle, no rsp_valid pulse, req_ready=1; a following store to 8'hFF completes normally.
- Ack arriving exactly at counter == TIMEOUT_CYCLES-1 (slave model delays ack) -> err=0 and data valid.
